// File: rtl/conv_row_pe.sv
// conv_row_pe: one filter-row processing element of the NoC convolution accelerator.
// Loads its filter row once per start. For each round it fetches one ifmap row, computes
// OW = IW-FW+1 sliding dot products (mod 256), and streams them to the adder node.
// Ports:
//   clk, reset           single rising-edge clock, synchronous active-high reset
//   start / done / busy  controller handshake (start pulse in, done pulse out)
//   pkt_in_*             router -> PE stream (read data, stray traffic discarded)
//   pkt_out_*            PE -> router stream (read requests, psums)
module conv_row_pe #(
    parameter int unsigned FILTER_WIDTH   = 3,
    parameter int unsigned IFMAP_WIDTH    = 7,
    parameter int unsigned TOT_ROUND      = 5,
    parameter logic [4:0]  NODE_INDEX     = 5'd3,
    parameter logic [4:0]  MEM_INDEX      = 5'd1,
    parameter logic [4:0]  SUM_INDEX      = 5'd21,
    parameter logic [7:0]  FILTER_POINTER = 8'd0,
    parameter logic [7:0]  IFMAP_POINTER  = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic        busy,
    input  logic        pkt_in_valid,
    output logic        pkt_in_ready,
    input  logic [19:0] pkt_in_data,
    output logic        pkt_out_valid,
    input  logic        pkt_out_ready,
    output logic [19:0] pkt_out_data
);
    localparam int unsigned FW  = FILTER_WIDTH;
    localparam int unsigned IW  = IFMAP_WIDTH;
    localparam int unsigned OW  = IW - FW + 1;
    localparam int unsigned TR  = TOT_ROUND;
    localparam int unsigned CW  = 5;
    localparam int unsigned RW  = (TR > 1) ? $clog2(TR) : 1;
    localparam int unsigned FIW = (FW > 1) ? $clog2(FW) : 1;
    localparam int unsigned XIW = (IW > 1) ? $clog2(IW) : 1;
    localparam int unsigned PIW = (OW > 1) ? $clog2(OW) : 1;

    localparam logic [1:0] T_RREQ  = 2'b00;
    localparam logic [1:0] T_RDATA = 2'b01;
    localparam logic [1:0] T_PSUM  = 2'b10;

    typedef struct packed {
        logic [4:0] dest;
        logic [1:0] ptype;
        logic [4:0] tag;
        logic [7:0] payload;
    } pkt_t;

    typedef enum logic [2:0] {
        S_IDLE, S_FREQ, S_FWAIT, S_IREQ, S_IWAIT, S_COMPUTE, S_SEND, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   k_q, k_d;
    logic [CW-1:0]   j_q, j_d;
    logic [RW-1:0]   r_q, r_d;
    logic [7:0]      f_q [FW];
    logic [7:0]      f_d [FW];
    logic [7:0]      x_q [IW];
    logic [7:0]      x_d [IW];
    logic [7:0]      p_q [OW];
    logic [7:0]      p_d [OW];

    logic            pkt_out_valid_q, pkt_out_valid_d;
    pkt_t            pkt_out_data_q, pkt_out_data_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            pkt_in_ready_q, pkt_in_ready_d;

    pkt_t            in_pkt;
    logic            out_fire_c;
    logic            in_fire_c;
    logic [7:0]      acc_c;
    logic [7:0]      ifmap_addr_c;
    logic            unused_in_tag;

    assign in_pkt        = pkt_t'(pkt_in_data);
    assign unused_in_tag = ^in_pkt.tag;

    // Next state, counters, buffers; outputs are registered from the next-state view
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        j_d      = j_q;
        r_d      = r_q;
        f_d      = f_q;
        x_d      = x_q;
        p_d      = p_q;
        acc_c    = '0;

        out_fire_c = pkt_out_valid_q & pkt_out_ready;
        // Only read data addressed to us is a response; everything else is silently consumed
        in_fire_c  = pkt_in_valid & pkt_in_ready_q &
                     (in_pkt.dest == NODE_INDEX) & (in_pkt.ptype == T_RDATA);

        // Dot product for column j_q, all arithmetic mod 256
        for (int unsigned i = 0; i < FW; i++) begin
            if (32'(j_q) + i < IW) begin
                acc_c = acc_c + 8'(f_q[FIW'(i)] * x_q[XIW'(32'(j_q) + i)]);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FREQ;
                    k_d     = '0;
                    r_d     = '0;
                end
            end
            S_FREQ: begin
                if (out_fire_c) state_d = S_FWAIT;
            end
            S_FWAIT: begin
                if (in_fire_c) begin
                    f_d[FIW'(k_q)] = in_pkt.payload;
                    if (k_q == CW'(FW - 1)) begin
                        k_d     = '0;
                        state_d = S_IREQ;
                    end else begin
                        k_d     = k_q + CW'(1);
                        state_d = S_FREQ;
                    end
                end
            end
            S_IREQ: begin
                if (out_fire_c) state_d = S_IWAIT;
            end
            S_IWAIT: begin
                if (in_fire_c) begin
                    x_d[XIW'(k_q)] = in_pkt.payload;
                    if (k_q == CW'(IW - 1)) begin
                        k_d     = '0;
                        j_d     = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        k_d     = k_q + CW'(1);
                        state_d = S_IREQ;
                    end
                end
            end
            S_COMPUTE: begin
                p_d[PIW'(j_q)] = acc_c;
                if (j_q == CW'(OW - 1)) begin
                    j_d     = '0;
                    state_d = S_SEND;
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            S_SEND: begin
                if (out_fire_c) begin
                    if (j_q == CW'(OW - 1)) begin
                        j_d = '0;
                        if (r_q == RW'(TR - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            r_d     = r_q + RW'(1);
                            k_d     = '0;
                            state_d = S_IREQ;
                        end
                    end else begin
                        j_d = j_q + CW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Round base wraps mod 256 along with the word offset
        ifmap_addr_c = IFMAP_POINTER + 8'(32'(r_d) * IW) + 8'(k_d);

        busy_d          = !(state_d inside {S_IDLE, S_DONE});
        done_d          = (state_d == S_DONE);
        pkt_in_ready_d  = (state_d != S_SEND);
        pkt_out_valid_d = (state_d inside {S_FREQ, S_IREQ, S_SEND});
        pkt_out_data_d  = '0;
        case (state_d)
            S_FREQ:  pkt_out_data_d = '{MEM_INDEX, T_RREQ, NODE_INDEX, FILTER_POINTER + 8'(k_d)};
            S_IREQ:  pkt_out_data_d = '{MEM_INDEX, T_RREQ, NODE_INDEX, ifmap_addr_c};
            S_SEND:  pkt_out_data_d = '{SUM_INDEX, T_PSUM, 5'(j_d), p_d[PIW'(j_d)]};
            default: pkt_out_data_d = '0;
        endcase
    end

    // State, buffers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            k_q             <= '0;
            j_q             <= '0;
            r_q             <= '0;
            f_q             <= '{default: '0};
            x_q             <= '{default: '0};
            p_q             <= '{default: '0};
            pkt_out_valid_q <= 1'b0;
            pkt_out_data_q  <= '0;
            done_q          <= 1'b0;
            busy_q          <= 1'b0;
            pkt_in_ready_q  <= 1'b1;
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            j_q             <= j_d;
            r_q             <= r_d;
            f_q             <= f_d;
            x_q             <= x_d;
            p_q             <= p_d;
            pkt_out_valid_q <= pkt_out_valid_d;
            pkt_out_data_q  <= pkt_out_data_d;
            done_q          <= done_d;
            busy_q          <= busy_d;
            pkt_in_ready_q  <= pkt_in_ready_d;
        end
    end

    assign pkt_out_valid = pkt_out_valid_q;
    assign pkt_out_data  = pkt_out_data_q;
    assign done          = done_q;
    assign busy          = busy_q;
    assign pkt_in_ready  = pkt_in_ready_q;

endmodule

// File: tb/tb_conv_row_pe.sv
// Testbench for conv_row_pe: memory node and adder-node sink models driven from a
// behavioural reference (expected request addresses and psum packets computed directly
// from filter/ifmap contents).
module tb_conv_row_pe;
    localparam int unsigned FW = 3;
    localparam int unsigned IW = 7;
    localparam int unsigned OW = IW - FW + 1;
    localparam int unsigned TR = 5;
    localparam logic [4:0]  NODE = 5'd3;
    localparam logic [4:0]  MEM  = 5'd1;
    localparam logic [4:0]  SUM  = 5'd21;
    localparam logic [7:0]  FP   = 8'd0;
    localparam logic [7:0]  IP   = 8'd0;

    logic        clk = 1'b0;
    logic        reset, start, done, busy;
    logic        pkt_in_valid, pkt_in_ready, pkt_out_valid, pkt_out_ready;
    logic [19:0] pkt_in_data, pkt_out_data;

    always #5 clk = ~clk;

    conv_row_pe #(
        .FILTER_WIDTH(FW), .IFMAP_WIDTH(IW), .TOT_ROUND(TR),
        .NODE_INDEX(NODE), .MEM_INDEX(MEM), .SUM_INDEX(SUM),
        .FILTER_POINTER(FP), .IFMAP_POINTER(IP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
        .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready), .pkt_in_data(pkt_in_data),
        .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready), .pkt_out_data(pkt_out_data)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [7:0]  fmem [256];
    logic [7:0]  xmem [256];
    logic [7:0]  exp_req  [$];
    logic [19:0] exp_psum [$];
    logic [19:0] in_q     [$];
    logic [7:0]  first_pay[$];
    int          in_gap = 0;
    int          req_seen = 0;
    int          psum_cnt = 0;
    int          done_cnt = 0;
    int          last_psum_cyc = 0;
    bit          stray_en = 0;
    bit          bp_arm = 0;
    int          bp_cycles = 0;
    bit          prev_stall = 0;
    logic [19:0] prev_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: full request address list and psum packet stream for one start
    task automatic build_model();
        int s;
        exp_req.delete();
        exp_psum.delete();
        first_pay.delete();
        in_q.delete();
        req_seen = 0;
        psum_cnt = 0;
        for (int k = 0; k < int'(FW); k++) exp_req.push_back(8'(32'(FP) + k));
        for (int r = 0; r < int'(TR); r++)
            for (int k = 0; k < int'(IW); k++) exp_req.push_back(8'(32'(IP) + r * IW + k));
        for (int r = 0; r < int'(TR); r++) begin
            for (int j = 0; j < int'(OW); j++) begin
                s = 0;
                for (int i = 0; i < int'(FW); i++)
                    s += int'(fmem[8'(32'(FP) + i)]) * int'(xmem[8'(32'(IP) + r * IW + j + i)]);
                exp_psum.push_back({SUM, 2'b10, 5'(j), 8'(s % 256)});
            end
        end
    endtask

    // Memory node + adder sink; all decisions at negedge for the following posedge
    initial begin
        logic [19:0] e;
        logic [7:0]  a;
        pkt_in_valid  = 1'b0;
        pkt_in_data   = '0;
        pkt_out_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                in_q.delete();
                in_gap        = 0;
                pkt_in_valid  = 1'b0;
                pkt_out_ready = 1'b0;
                prev_stall    = 0;
                bp_cycles     = 0;
            end else begin
                if (done) begin
                    done_cnt++;
                    check_eq("done_all_psums", exp_psum.size(), 0);
                    check_eq("done_timing", cyc, last_psum_cyc + 1);
                    check_eq("busy_low_with_done", busy, 0);
                end
                if (prev_stall) begin
                    check_eq("stall_valid_hold", pkt_out_valid, 1);
                    check_eq("stall_data_hold", pkt_out_data, prev_data);
                end
                // Router -> PE
                if (in_q.size() > 0 && in_gap == 0) begin
                    pkt_in_valid = 1'b1;
                    pkt_in_data  = in_q[0];
                    if (pkt_in_ready) begin
                        void'(in_q.pop_front());
                        in_gap = $urandom_range(0, 2);
                    end
                end else begin
                    pkt_in_valid = 1'b0;
                    pkt_in_data  = 20'($urandom);
                    if (in_gap > 0) in_gap--;
                end
                // PE -> router
                if (bp_arm && pkt_out_valid && pkt_out_data[14:13] == 2'b10) begin
                    bp_arm    = 0;
                    bp_cycles = 10;
                end
                if (bp_cycles > 0) begin
                    pkt_out_ready = 1'b0;
                    bp_cycles--;
                end else begin
                    pkt_out_ready = ($urandom_range(0, 3) != 0);
                end
                prev_stall = pkt_out_valid && !pkt_out_ready;
                prev_data  = pkt_out_data;
                if (pkt_out_valid && pkt_out_ready) begin
                    if (pkt_out_data[14:13] == 2'b00) begin
                        e = (exp_req.size() > 0) ? {MEM, 2'b00, NODE, exp_req.pop_front()} : 20'hFFFFF;
                        check_eq("req_pkt", pkt_out_data, e);
                        a = pkt_out_data[7:0];
                        if (stray_en && req_seen < int'(FW)) begin
                            in_q.push_back({5'd5, 2'b01, MEM, 8'hAA});
                            in_q.push_back({NODE, 2'b10, MEM, 8'h55});
                        end
                        in_q.push_back({NODE, 2'b01, MEM, (req_seen < int'(FW)) ? fmem[a] : xmem[a]});
                        req_seen++;
                    end else begin
                        e = (exp_psum.size() > 0) ? exp_psum.pop_front() : 20'hFFFFF;
                        check_eq("psum_pkt", pkt_out_data, e);
                        if (first_pay.size() < OW) first_pay.push_back(pkt_out_data[7:0]);
                        psum_cnt++;
                        last_psum_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic run_one(input bit extra_starts);
        int d0;
        int t;
        d0 = done_cnt;
        t  = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_rise", busy, 1);
        check_eq("first_req_valid", pkt_out_valid, 1);
        check_eq("first_req_data", pkt_out_data, {MEM, 2'b00, NODE, FP});
        while (done_cnt == d0 && t < 5000) begin
            @(negedge clk);
            t++;
            start = extra_starts && (t == 40 || t == 120);
        end
        start = 1'b0;
        check_eq("done_seen", done_cnt, d0 + 1);
        repeat (4) @(negedge clk);
        check_eq("single_done", done_cnt, d0 + 1);
        check_eq("idle_busy", busy, 0);
        check_eq("no_leftover_req", exp_req.size(), 0);
    endtask

    task automatic randomize_mem();
        for (int a = 0; a < 256; a++) begin
            fmem[a] = 8'($urandom);
            xmem[a] = 8'($urandom);
        end
    endtask

    initial begin
        int t;
        int d0;
        logic [7:0] exp_row0 [5];
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", pkt_out_valid, 0);
        check_eq("rst_out_data", pkt_out_data, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", pkt_in_ready, 1);
        reset = 1'b0;

        // Directed: f=[1,2,3], ifmap word = address
        for (int a = 0; a < 256; a++) begin
            fmem[a] = 8'd0;
            xmem[a] = 8'(a);
        end
        fmem[0] = 8'd1; fmem[1] = 8'd2; fmem[2] = 8'd3;
        build_model();
        run_one(0);
        exp_row0 = '{8'd8, 8'd14, 8'd20, 8'd26, 8'd32};
        for (int i = 0; i < 5; i++) check_eq("row0_psum", first_pay[i], exp_row0[i]);
        check_eq("psum_count", psum_cnt, TR * OW);

        // Overflow: every psum wraps to 250
        for (int a = 0; a < 256; a++) begin
            fmem[a] = 8'd255;
            xmem[a] = 8'd2;
        end
        build_model();
        run_one(0);
        for (int i = 0; i < 5; i++) check_eq("overflow_psum", first_pay[i], 250);

        // Backpressure during SEND
        randomize_mem();
        build_model();
        bp_arm = 1;
        run_one(0);

        // Stray traffic while filter words are outstanding
        randomize_mem();
        build_model();
        stray_en = 1;
        run_one(0);
        stray_en = 0;

        // Start pulsed while busy
        randomize_mem();
        build_model();
        run_one(1);

        // Reset after the 3rd psum of round 2, then a full rerun
        randomize_mem();
        build_model();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (psum_cnt < int'(2 * OW + 3) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_eq("reached_round2", psum_cnt >= int'(2 * OW + 3), 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_out_valid", pkt_out_valid, 0);
        check_eq("abort_out_data", pkt_out_data, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_in_ready", pkt_in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("abort_no_done", done_cnt, d0);
        build_model();
        run_one(0);

        // Random runs
        for (int n = 0; n < 3; n++) begin
            randomize_mem();
            build_model();
            run_one(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
